stopwatch_counter: RTL

- Produces the four BCD digits (mm:ss) that feed the stopwatch display block's min_l/min_r/sec_l/sec_r inputs.
- Converts raw start/stop and clear button levels into clean run/pause/clear control.
- Divides the system clock into a 1 Hz count enable and advances a cascaded BCD minute:second counter from 00:00 to 59:59 with wrap.

---
 rtl/stopwatch_counter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: mm:ss stopwatch core.
// Conditions the start/stop and clear buttons, divides clk down to a
// one-second count enable and drives a cascaded BCD counter 00:00..59:59.
module stopwatch_counter #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned DIV_W         = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       running,
  output logic       sec_tick,
  output logic       rollover
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICKS_PER_SEC - 1);

  state_t           state_q, state_d;

  // Button conditioning: two synchroniser stages plus previous-value flop.
  logic [1:0]       ss_sync_q;
  logic             ss_prev_q;
  logic [1:0]       clr_sync_q;
  logic             clr_prev_q;
  logic             ss_pulse;
  logic             clr_pulse;

  logic [DIV_W-1:0] div_q, div_d;

  logic [3:0]       min_l_q, min_l_d;
  logic [3:0]       min_r_q, min_r_d;
  logic [3:0]       sec_l_q, sec_l_d;
  logic [3:0]       sec_r_q, sec_r_d;

  logic             running_q;
  logic             sec_tick_q;
  logic             rollover_q;

  logic             div_wrap;
  logic             inc;
  logic             at_max;

  // Synchronise the raw button levels and remember the last synchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_q  <= '0;
      ss_prev_q  <= 1'b0;
      clr_sync_q <= '0;
      clr_prev_q <= 1'b0;
    end else begin
      ss_sync_q  <= {ss_sync_q[0], btn_start_stop};
      ss_prev_q  <= ss_sync_q[1];
      clr_sync_q <= {clr_sync_q[0], btn_clear};
      clr_prev_q <= clr_sync_q[1];
    end
  end

  assign ss_pulse  = ss_sync_q[1]  & ~ss_prev_q;
  assign clr_pulse = clr_sync_q[1] & ~clr_prev_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides a simultaneous start/stop.
  always_comb begin
    state_d = state_q;
    if (clr_pulse) begin
      state_d = IDLE;
    end else if (ss_pulse) begin
      unique case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end
  end

  // Count-enable decode: a wrap only counts when neither button acts this cycle.
  always_comb begin
    div_wrap = (state_q == RUNNING) && (div_q == DIV_MAX);
    inc      = div_wrap && !clr_pulse && !ss_pulse;
    at_max   = (min_l_q == 4'd5) && (min_r_q == 4'd9) &&
               (sec_l_q == 4'd5) && (sec_r_q == 4'd9);
  end

  // Divider next value: cleared in IDLE, frozen when paused or being paused.
  always_comb begin
    div_d = div_q;
    if (clr_pulse || (state_q == IDLE)) begin
      div_d = '0;
    end else if ((state_q == RUNNING) && !ss_pulse) begin
      if (div_wrap) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // BCD cascade: each digit wraps only when every lower digit carries.
  always_comb begin
    min_l_d = min_l_q;
    min_r_d = min_r_q;
    sec_l_d = sec_l_q;
    sec_r_d = sec_r_q;
    if (clr_pulse || (state_q == IDLE)) begin
      min_l_d = '0;
      min_r_d = '0;
      sec_l_d = '0;
      sec_r_d = '0;
    end else if (inc) begin
      if (sec_r_q == 4'd9) begin
        sec_r_d = '0;
        if (sec_l_q == 4'd5) begin
          sec_l_d = '0;
          if (min_r_q == 4'd9) begin
            min_r_d = '0;
            if (min_l_q == 4'd5) begin
              min_l_d = '0;
            end else begin
              min_l_d = min_l_q + 4'd1;
            end
          end else begin
            min_r_d = min_r_q + 4'd1;
          end
        end else begin
          sec_l_d = sec_l_q + 4'd1;
        end
      end else begin
        sec_r_d = sec_r_q + 4'd1;
      end
    end
  end

  // Datapath registers: divider and digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      min_l_q <= '0;
      min_r_q <= '0;
      sec_l_q <= '0;
      sec_r_q <= '0;
    end else begin
      div_q   <= div_d;
      min_l_q <= min_l_d;
      min_r_q <= min_r_d;
      sec_l_q <= sec_l_d;
      sec_r_q <= sec_r_d;
    end
  end

  // Registered status outputs, aligned with the digit values they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      running_q  <= (state_d == RUNNING);
      sec_tick_q <= inc;
      rollover_q <= inc && at_max;
    end
  end

  assign min_l    = {1'b0, min_l_q};
  assign min_r    = {1'b0, min_r_q};
  assign sec_l    = {1'b0, sec_l_q};
  assign sec_r    = {1'b0, sec_r_q};
  assign running  = running_q;
  assign sec_tick = sec_tick_q;
  assign rollover = rollover_q;

endmodule
